multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS-subset CPU. Sequences fetch, decode, execute, memory and write-back, and drives every datapath select. This includes the ALU-B source mux that picks among register rt and the three extender outputs: sign-extended imm16, zero-extended imm16, and shamt. It sits between the instruction register, the instruction/data memory handshakes and the datapath muxes and enables.

---
 rtl/cpu_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/ctrl_decode.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// funct codes and datapath select values.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu     = 4'd0,
    ClsLoad    = 4'd1,
    ClsStore   = 4'd2,
    ClsBeq     = 4'd3,
    ClsBne     = 4'd4,
    ClsJump    = 4'd5,
    ClsJal     = 4'd6,
    ClsSyscall = 4'd7,
    ClsIllegal = 4'd8
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [1:0] BSEL_RT    = 2'd0;
  localparam logic [1:0] BSEL_SEXT  = 2'd1;
  localparam logic [1:0] BSEL_ZEXT  = 2'd2;
  localparam logic [1:0] BSEL_SHAMT = 2'd3;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WDSEL_ALU  = 2'd0;
  localparam logic [1:0] WDSEL_MEM  = 2'd1;
  localparam logic [1:0] WDSEL_LINK = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory request/acknowledge handshakes.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU op and
// ALU-B source select.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]  ir_d,
    output instr_class_e cls,
    output logic [3:0]   alu_op,
    output logic [1:0]   alu_b_sel,
    output logic         is_rtype,
    output logic         legal
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_ir;

    assign op        = ir_d[31:26];
    assign funct     = ir_d[5:0];
    assign unused_ir = ^ir_d[25:6];

    always_comb begin
        cls       = ClsAlu;
        alu_op    = ALU_ADD;
        alu_b_sel = BSEL_RT;
        is_rtype  = (op == OP_RTYPE);
        legal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:     alu_op = ALU_ADD;
                    FN_SUB:     alu_op = ALU_SUB;
                    FN_AND:     alu_op = ALU_AND;
                    FN_OR:      alu_op = ALU_OR;
                    FN_SLT:     alu_op = ALU_SLT;
                    FN_SLL:     begin alu_op = ALU_SLL; alu_b_sel = BSEL_SHAMT; end
                    FN_SRL:     begin alu_op = ALU_SRL; alu_b_sel = BSEL_SHAMT; end
                    FN_SRA:     begin alu_op = ALU_SRA; alu_b_sel = BSEL_SHAMT; end
                    FN_SYSCALL: cls = ClsSyscall;
                    default:    begin cls = ClsIllegal; legal = 1'b0; end
                endcase
            end
            OP_ADDI, OP_ADDIU: alu_b_sel = BSEL_SEXT;
            OP_SLTI:  begin alu_op = ALU_SLT; alu_b_sel = BSEL_SEXT; end
            OP_ANDI:  begin alu_op = ALU_AND; alu_b_sel = BSEL_ZEXT; end
            OP_ORI:   begin alu_op = ALU_OR;  alu_b_sel = BSEL_ZEXT; end
            OP_XORI:  begin alu_op = ALU_XOR; alu_b_sel = BSEL_ZEXT; end
            OP_LW:    begin cls = ClsLoad;  alu_b_sel = BSEL_SEXT; end
            OP_SW:    begin cls = ClsStore; alu_b_sel = BSEL_SEXT; end
            OP_BEQ:   begin cls = ClsBeq; alu_op = ALU_SUB; end
            OP_BNE:   begin cls = ClsBne; alu_op = ALU_SUB; end
            OP_J:     cls = ClsJump;
            OP_JAL:   cls = ClsJal;
            default:  begin cls = ClsIllegal; legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/wb and drives all
// datapath selects and enables as Moore decodes of state and the current IR.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ir_d,
    input  logic              alu_zero,
    multicycle_ctrl_if.master mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic [1:0]        alu_b_sel,
    output logic [3:0]        alu_op,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic [1:0]        wd_sel,
    output logic              halted,
    output logic              illegal
);

    state_e       state_q, state_d;
    logic         illegal_q, illegal_d;
    instr_class_e dec_cls;
    logic [3:0]   dec_alu_op;
    logic [1:0]   dec_b_sel;
    logic         dec_is_rtype;
    logic         dec_legal;
    logic         imem_req, dmem_req, dmem_we;

    ctrl_decode u_decode (
        .ir_d      (ir_d),
        .cls       (dec_cls),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_b_sel),
        .is_rtype  (dec_is_rtype),
        .legal     (dec_legal)
    );

    // Async reset forces StReset, so every request/enable drops in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PCSRC_PC4;
        alu_b_sel = BSEL_RT;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        reg_dst   = REGDST_RT;
        wd_sel    = WDSEL_ALU;
        halted    = 1'b0;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end else if (dec_cls == ClsSyscall) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_b_sel = dec_b_sel;
                alu_op    = dec_alu_op;
                case (dec_cls)
                    ClsBeq: begin
                        pc_we   = alu_zero;
                        pc_src  = PCSRC_BRANCH;
                        state_d = StFetch;
                    end
                    ClsBne: begin
                        pc_we   = !alu_zero;
                        pc_src  = PCSRC_BRANCH;
                        state_d = StFetch;
                    end
                    ClsJump: begin
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_JUMP;
                        state_d = StFetch;
                    end
                    ClsJal: begin
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_JUMP;
                        reg_we  = 1'b1;
                        reg_dst = REGDST_R31;
                        wd_sel  = WDSEL_LINK;
                        state_d = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsAlu:            state_d = StWb;
                    default:           state_d = StFetch;
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_cls == ClsStore);
                if (mem.dmem_ack) begin
                    state_d = (dec_cls == ClsStore) ? StFetch : StWb;
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                reg_dst = dec_is_rtype ? REGDST_RD : REGDST_RT;
                wd_sel  = (dec_cls == ClsLoad) ? WDSEL_MEM : WDSEL_ALU;
                state_d = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StReset;
        endcase
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are
// queued as stimulus is driven and compared at the following falling edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_b_sel;
        logic [3:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       halted;
        logic       illegal;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir_d = 32'h0;
    logic        alu_zero = 1'b0;
    logic        ir_we, pc_we, reg_we, halted, illegal;
    logic [1:0]  pc_src, alu_b_sel, reg_dst, wd_sel;
    logic [3:0]  alu_op;

    int    n_checks = 0;
    int    n_pass = 0;
    logic  exp_ill = 1'b0;
    outs_t exp_q[$];
    string tag_q[$];

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ir_d      (ir_d),
        .alu_zero  (alu_zero),
        .mem       (mem_if.master),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic outs_t observe();
        outs_t v;
        v.imem_req  = mem_if.imem_req;
        v.dmem_req  = mem_if.dmem_req;
        v.dmem_we   = mem_if.dmem_we;
        v.ir_we     = ir_we;
        v.pc_we     = pc_we;
        v.pc_src    = pc_src;
        v.alu_b_sel = alu_b_sel;
        v.alu_op    = alu_op;
        v.reg_we    = reg_we;
        v.reg_dst   = reg_dst;
        v.wd_sel    = wd_sel;
        v.halted    = halted;
        v.illegal   = illegal;
        return v;
    endfunction

    function automatic outs_t e_idle();
        outs_t v = '0;
        v.illegal = exp_ill;
        return v;
    endfunction

    function automatic outs_t e_fetch(input logic ack);
        outs_t v = e_idle();
        v.imem_req = 1'b1;
        v.ir_we    = ack;
        v.pc_we    = ack;
        return v;
    endfunction

    function automatic outs_t e_exec(input logic [1:0] bsel, input logic [3:0] op);
        outs_t v = e_idle();
        v.alu_b_sel = bsel;
        v.alu_op    = op;
        return v;
    endfunction

    function automatic outs_t e_branch(input logic pcwe);
        outs_t v = e_exec(2'd0, 4'd1);
        v.pc_we  = pcwe;
        v.pc_src = 2'd1;
        return v;
    endfunction

    function automatic outs_t e_jump(input logic link);
        outs_t v = e_idle();
        v.pc_we  = 1'b1;
        v.pc_src = 2'd2;
        if (link) begin
            v.reg_we  = 1'b1;
            v.reg_dst = 2'd2;
            v.wd_sel  = 2'd2;
        end
        return v;
    endfunction

    function automatic outs_t e_mem(input logic we);
        outs_t v = e_idle();
        v.dmem_req = 1'b1;
        v.dmem_we  = we;
        return v;
    endfunction

    function automatic outs_t e_wb(input logic [1:0] dst, input logic [1:0] wd);
        outs_t v = e_idle();
        v.reg_we  = 1'b1;
        v.reg_dst = dst;
        v.wd_sel  = wd;
        return v;
    endfunction

    function automatic outs_t e_halt();
        outs_t v = e_idle();
        v.halted = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input outs_t got, input outs_t exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, compare at negedge.
    task automatic cyc(input string tag, input logic ia, input logic da, input outs_t e);
        mem_if.imem_ack = ia;
        mem_if.dmem_ack = da;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check(tag_q.pop_front(), observe(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] instr);
        ir_d = instr;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, e_fetch(1'b1));
        cyc({tag, "_decode"}, 1'b0, 1'b0, e_idle());
    endtask

    task automatic run_alu(input string tag, input logic [31:0] instr, input logic [1:0] bsel,
                           input logic [3:0] op, input logic [1:0] dst);
        fetch_decode(tag, instr);
        cyc({tag, "_exec"}, 1'b0, 1'b0, e_exec(bsel, op));
        cyc({tag, "_wb"}, 1'b0, 1'b0, e_wb(dst, 2'd0));
    endtask

    initial begin
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", observe(), e_idle());
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset_release", 1'b1, 1'b0, e_idle());

        // Fetch wait state, then addi completes in 4 cycles.
        ir_d = 32'h20080005;
        cyc("addi_fetch_wait", 1'b0, 1'b0, e_fetch(1'b0));
        run_alu("addi", 32'h20080005, 2'd1, 4'd0, 2'd0);
        run_alu("ori", 32'h3508FFFF, 2'd2, 4'd3, 2'd0);
        run_alu("sll", 32'h00084080, 2'd3, 4'd6, 2'd1);
        run_alu("sub", 32'h01095022, 2'd0, 4'd1, 2'd1);

        // lw with three data wait cycles: 8 cycles total.
        fetch_decode("lw", 32'h8C090004);
        cyc("lw_exec", 1'b0, 1'b0, e_exec(2'd1, 4'd0));
        cyc("lw_mem0", 1'b0, 1'b0, e_mem(1'b0));
        cyc("lw_mem1", 1'b0, 1'b0, e_mem(1'b0));
        cyc("lw_mem2", 1'b0, 1'b0, e_mem(1'b0));
        cyc("lw_mem3", 1'b0, 1'b1, e_mem(1'b0));
        cyc("lw_wb", 1'b0, 1'b0, e_wb(2'd0, 2'd1));

        // sw with zero-wait ack: 4 cycles, straight back to fetch.
        fetch_decode("sw", 32'hAD090004);
        cyc("sw_exec", 1'b0, 1'b0, e_exec(2'd1, 4'd0));
        cyc("sw_mem", 1'b0, 1'b1, e_mem(1'b1));

        alu_zero = 1'b1;
        fetch_decode("beq", 32'h1109FFFE);
        cyc("beq_exec", 1'b0, 1'b0, e_branch(1'b1));
        fetch_decode("bne", 32'h1509FFFE);
        cyc("bne_exec", 1'b0, 1'b0, e_branch(1'b0));
        alu_zero = 1'b0;
        fetch_decode("bne_nz", 32'h1509FFFE);
        cyc("bne_nz_exec", 1'b0, 1'b0, e_branch(1'b1));

        fetch_decode("j", 32'h08000010);
        cyc("j_exec", 1'b0, 1'b0, e_jump(1'b0));
        fetch_decode("jal", 32'h0C000010);
        cyc("jal_exec", 1'b0, 1'b0, e_jump(1'b1));

        // Unsupported opcode: flag goes sticky, no write, fetch continues.
        fetch_decode("illegal", 32'hFC000000);
        exp_ill = 1'b1;
        run_alu("after_illegal", 32'h20080005, 2'd1, 4'd0, 2'd0);

        // Reset mid-MEM wait drops dmem_req asynchronously and clears illegal.
        fetch_decode("lw_rst", 32'h8C090004);
        cyc("lw_rst_exec", 1'b0, 1'b0, e_exec(2'd1, 4'd0));
        cyc("lw_rst_mem0", 1'b0, 1'b0, e_mem(1'b0));
        #2;
        rst = 1'b1;
        exp_ill = 1'b0;
        #1;
        check("rst_async_drop", observe(), e_idle());
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst_restart_reset", 1'b0, 1'b0, e_idle());
        ir_d = 32'h3508FFFF;
        cyc("rst_restart_fetch_wait", 1'b0, 1'b0, e_fetch(1'b0));
        run_alu("rst_restart_ori", 32'h3508FFFF, 2'd2, 4'd3, 2'd0);

        // syscall halts; imem_ack held high must not restart fetch.
        fetch_decode("syscall", 32'h0000000C);
        for (int i = 0; i < 4; i++) begin
            cyc("halt_hold", 1'b1, 1'b1, e_halt());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
